num_to_mors: RTL and testbench

//  Morse transmitter for decimal digits: the sending end of the digit-Morse serial line.

---
 rtl/morse_pkg.sv | 39 +++
 rtl/morse_digit_lut.sv | 16 +
 rtl/num_to_mors.sv | 130 +++++++++++++
 tb/tb_num_to_mors.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the digit-Morse serial line (transmitter and receiver).
//   state_t           : FSM states of the transmitter/receiver
//   DOT_UNITS/DASH_UNITS : mark lengths in Morse time units
//   SYMS_PER_DIGIT    : elements per digit
//   digit_to_pattern  : digit -> 5-bit element pattern, 1 = dash, bit 4 sent first
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    DGAP  = 2'd3
  } state_t;

  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned SYMS_PER_DIGIT = 5;

  // Non-digit codes map to all-dots; callers must qualify with a range check.
  function automatic logic [SYMS_PER_DIGIT-1:0] digit_to_pattern(input logic [3:0] d);
    logic [SYMS_PER_DIGIT-1:0] p;
    p = 5'b00000;
    case (d)
      4'd0: p = 5'b11111;
      4'd1: p = 5'b01111;
      4'd2: p = 5'b00111;
      4'd3: p = 5'b00011;
      4'd4: p = 5'b00001;
      4'd5: p = 5'b00000;
      4'd6: p = 5'b10000;
      4'd7: p = 5'b11000;
      4'd8: p = 5'b11100;
      4'd9: p = 5'b11110;
      default: p = 5'b00000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_digit_lut.sv
// Combinational digit lookup.
//   digit   in  4 : binary digit
//   valid   out 1 : digit is in 0..9
//   pattern out 5 : element pattern, 1 = dash, bit 4 first
module morse_digit_lut
  import morse_pkg::*;
(
  input  logic [3:0]                digit,
  output logic                      valid,
  output logic [SYMS_PER_DIGIT-1:0] pattern
);

  assign valid   = (digit <= 4'd9);
  assign pattern = digit_to_pattern(digit);

endmodule

// File: rtl/num_to_mors.sv
// Morse transmitter for decimal digits.
//   clk          in  1 : clock, posedge
//   rst          in  1 : synchronous reset, active-high
//   digit        in  4 : digit to send (0..9)
//   digit_valid  in  1 : source offers a digit
//   digit_ready  out 1 : block can accept (IDLE only), decoded from state
//   mors         out 1 : Morse line, 1 = key down (registered)
//   busy         out 1 : transmission in progress (registered)
//   err          out 1 : one-cycle pulse for a discarded digit >9 (registered)
module num_to_mors
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1,
  parameter int unsigned ELEM_GAP    = 1,
  parameter int unsigned DIGIT_GAP   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       mors,
  output logic       busy,
  output logic       err
);

  localparam int unsigned MAX_GAP   = (ELEM_GAP > DIGIT_GAP) ? ELEM_GAP : DIGIT_GAP;
  localparam int unsigned MAX_UNITS = (MAX_GAP > DASH_UNITS) ? MAX_GAP : DASH_UNITS;
  localparam int unsigned CNT_W     = $clog2(MAX_UNITS * UNIT_CYCLES + 1);
  localparam int unsigned IDX_W     = $clog2(SYMS_PER_DIGIT);

  // Counters are loaded with (duration - 1) and count down to zero.
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] EGAP_LOAD = CNT_W'(ELEM_GAP * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DGAP_LOAD = CNT_W'(DIGIT_GAP * UNIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SYMS_PER_DIGIT - 1);

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [SYMS_PER_DIGIT-1:0] pat, pat_n;
  logic                      err_n;
  logic                      lut_valid;
  logic [SYMS_PER_DIGIT-1:0] lut_pattern;

  morse_digit_lut u_lut (
    .digit   (digit),
    .valid   (lut_valid),
    .pattern (lut_pattern)
  );

  assign digit_ready = (state == IDLE);

  // State, datapath and registered outputs; outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      pat   <= '0;
      mors  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      pat   <= pat_n;
      mors  <= (state_n == MARK);
      busy  <= (state_n != IDLE);
      err   <= err_n;
    end
  end

  // Next-state and datapath; pat[4] always holds the current/next element.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    pat_n   = pat;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (digit_valid) begin
          if (lut_valid) begin
            state_n = MARK;
            pat_n   = lut_pattern;
            idx_n   = '0;
            cnt_n   = lut_pattern[SYMS_PER_DIGIT-1] ? DASH_LOAD : DOT_LOAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt == '0) begin
          if (idx == LAST_IDX) begin
            state_n = DGAP;
            cnt_n   = DGAP_LOAD;
          end else begin
            state_n = SPACE;
            cnt_n   = EGAP_LOAD;
            idx_n   = idx + IDX_W'(1);
            pat_n   = {pat[SYMS_PER_DIGIT-2:0], 1'b0};
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SPACE: begin
        if (cnt == '0) begin
          state_n = MARK;
          cnt_n   = pat[SYMS_PER_DIGIT-1] ? DASH_LOAD : DOT_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DGAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_num_to_mors.sv
module tb_num_to_mors;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit, digit2;
  logic       digit_valid, digit_valid2;
  logic       digit_ready, digit_ready2;
  logic       mors, mors2;
  logic       busy, busy2;
  logic       err, err2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  num_to_mors u_dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .mors        (mors),
    .busy        (busy),
    .err         (err)
  );

  num_to_mors #(.UNIT_CYCLES(2)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit2),
    .digit_valid (digit_valid2),
    .digit_ready (digit_ready2),
    .mors        (mors2),
    .busy        (busy2),
    .err         (err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks a mors sequence (MSB first) cycle by cycle, busy high throughout.
  task automatic run_seq(input string tag, input logic [63:0] seq, input int len,
                         input bit second);
    for (int i = 0; i < len; i++) begin
      if (second) begin
        chk({tag, "_mors"}, mors2, seq[len-1-i]);
        chk({tag, "_busy"}, busy2, 1'b1);
      end else begin
        chk({tag, "_mors"}, mors, seq[len-1-i]);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_ready"}, digit_ready, 1'b0);
      end
      tick();
    end
  endtask

  logic [63:0] s;

  initial begin
    rst          = 1'b1;
    digit        = 4'd0;
    digit_valid  = 1'b0;
    digit2       = 4'd0;
    digit_valid2 = 1'b0;

    // 1: reset held 3 cycles, then idle for 20 cycles
    tick(); tick(); tick();
    chk("rst_mors", mors, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", digit_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_mors", mors, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_err", err, 1'b0);
      chk("idle_ready", digit_ready, 1'b1);
    end

    // 2: digit 5 with defaults
    digit = 4'd5; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0; digit = 4'd9;
    s = 64'b101010101000;
    run_seq("d5", s, 12, 1'b0);
    chk("d5_ready13", digit_ready, 1'b1);
    chk("d5_busy13", busy, 1'b0);
    chk("d5_mors13", mors, 1'b0);

    // 3: digit 7 with UNIT_CYCLES=2
    digit2 = 4'd7; digit_valid2 = 1'b1;
    tick();
    digit_valid2 = 1'b0;
    s = 64'b11111100111111001100110011000000;
    run_seq("d7u2", s, 32, 1'b1);
    chk("d7u2_ready", digit_ready2, 1'b1);
    chk("d7u2_busy", busy2, 1'b0);

    // 4: digit 0 then 1 back-to-back with valid held
    digit = 4'd0; digit_valid = 1'b1;
    tick();
    digit = 4'd1;
    s = 64'b1110111011101110111000;
    run_seq("d0", s, 22, 1'b0);
    chk("b2b_ready", digit_ready, 1'b1);
    chk("b2b_gap_mors", mors, 1'b0);
    tick();
    digit_valid = 1'b0;
    s = 64'b10111011101110111000;
    run_seq("d1", s, 20, 1'b0);
    chk("d1_ready", digit_ready, 1'b1);

    // 5: invalid digit 12 then digit 3
    digit = 4'd12; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("inv_err", err, 1'b1);
    chk("inv_mors", mors, 1'b0);
    chk("inv_busy", busy, 1'b0);
    chk("inv_ready", digit_ready, 1'b1);
    tick();
    chk("inv_err_clr", err, 1'b0);
    chk("inv_mors2", mors, 1'b0);
    digit = 4'd3; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("d3_err", err, 1'b0);
    s = 64'b1010101110111000;
    run_seq("d3", s, 16, 1'b0);
    chk("d3_ready", digit_ready, 1'b1);

    // 6: reset during 3rd element of digit 8, then digit 2
    digit = 4'd8; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    s = 64'b11101110;
    run_seq("d8", s, 8, 1'b0);
    chk("d8_elem3_mors", mors, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_mors", mors, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", digit_ready, 1'b1);
    tick();
    chk("abort_idle_mors", mors, 1'b0);
    digit = 4'd2; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    s = 64'b101011101110111000;
    run_seq("d2", s, 18, 1'b0);
    chk("d2_ready", digit_ready, 1'b1);
    chk("d2_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
